steering_arbiter: RTL and testbench
===================================

// Module: steering_arbiter
// PURPOSE
//  Owns the electric power steering actuator and shares it between the lane assist FSM and the park assist requester.
//  Lane requests are debounced, capped in duration and followed by a cooldown; driver steering torque overrides all.
//  Sits between lane_assist/park assist and the EPS driver stage in the body control module.
// PARAMETERS
//  DEBOUNCE_CYCLES     4    consecutive cycles a lane departure code must be held before correction (>=2)
//  MAX_CORRECT_CYCLES  200  max cycles steer_en may stay high for one lane correction
//  COOLDOWN_CYCLES     50   cycles lane correction is blocked after a correction ends
//  CNT_W               8    counter width; must hold max(MAX_CORRECT_CYCLES, COOLDOWN_CYCLES)
// PORTS
//  CLK              in   1  system clock
//  RST              in   1  synchronous, active-high reset
//  lane             in   3  lane assist code: 010 enabled, 000 disabled, 001 assist right, 100 assist left
//  driver_override  in   1  driver steering torque detected
//  park_req         in   1  park assist requests actuator (level, held while needed)
//  park_dir         in   2  park steer direction {left,right}
//  steer_en         out  1  actuator enable
//  steer_dir        out  2  {left,right}; 00 none
//  grant            out  2  00 none, 01 lane assist, 10 park assist
//  timeout_flag     out  1  1-cycle pulse when a lane correction hits MAX_CORRECT_CYCLES
// BEHAVIOUR
//  - One clock, CLK; reset synchronous, active-high on RST. All outputs registered; they change on the edge that enters a state.
//  - Reset, including mid-operation: on the next edge, state=IDLE, counter=0, latched dir=00, all outputs 0.
//  - Priority every cycle: driver_override > park_req > lane. lane codes 001 and 100 are requests.
//    Every other lane code, including invalid 011/101/110/111, is no request.
//  - IDLE: all outputs 0.
//    override->OVERRIDE; park_req->PARK_ACTIVE; lane request->DEBOUNCE, latch dir, cnt=1.
//  - DEBOUNCE: outputs 0. override/park as in IDLE. lane != latched code -> IDLE.
//    cnt==DEBOUNCE_CYCLES-1 -> LANE_ACTIVE with cnt=0; else cnt++.
//    steer_en rises DEBOUNCE_CYCLES-1 edges after the edge that first samples the request.
//  - LANE_ACTIVE: steer_en=1, grant=01, steer_dir = latched (001->01, 100->10); park_req ignored.
//    override -> OVERRIDE.
//    lane != latched -> COOLDOWN, cnt=0.
//    cnt==MAX_CORRECT_CYCLES-1 -> COOLDOWN with timeout_flag=1 for that single cycle; else cnt++.
//  - COOLDOWN: outputs 0; lane requests ignored. override->OVERRIDE; park_req->PARK_ACTIVE.
//    cnt==COOLDOWN_CYCLES-1 -> IDLE; a still-held lane request then re-debounces.
//  - PARK_ACTIVE: grant=10, steer_dir<=park_dir, steer_en<=(park_dir==01|park_dir==10) (1-cycle lag).
//    park_dir==11 gives steer_en=0, dir=00. override->OVERRIDE; !park_req->IDLE.
//  - OVERRIDE: all outputs 0, latched dir cleared; !driver_override -> IDLE.
//  - Counters never wrap: each state reloads the counter on entry.
// CONFIGURATION
//  - Macro LANE_WARN_CHIME_EN defined: adds output lane_warn (1b) and parameter WARN_HALF_PERIOD (default 16).
//    lane_warn toggles every WARN_HALF_PERIOD cycles while in LANE_ACTIVE, starting at 1 on the entry edge.
//    lane_warn is 0 in all other states and after reset.
//  - Macro not defined: no lane_warn port and no chime logic; all other behaviour identical.
// STRUCTURE
//  - Package steer_arb_pkg: state enum (IDLE, DEBOUNCE, LANE_ACTIVE, COOLDOWN, PARK_ACTIVE, OVERRIDE).
//    Also holds the grant codes, the dir codes and the lane codes ENABLE/DISABLE/ASSIST_RIGHT/ASSIST_LEFT, shared with lane assist.
//  - One sub-module, lane_warn_chime, instantiated only under LANE_WARN_CHIME_EN; FSM and the single counter stay in the top.
// TESTING
//  - Reset: RST=1 during LANE_ACTIVE -> next edge steer_en=0, grant=00, timeout_flag=0, state IDLE.
//  - Debounce: lane=001 held 4 cycles -> steer_en=1, steer_dir=01, grant=01.
//    lane=100 for 2 cycles then 010 -> steer_en never rises.
//  - Timeout: lane=100 held 300 cycles.
//    -> steer_en high exactly 200 cycles, timeout_flag one pulse, 50 cycles idle, then re-debounce.
//  - Override: driver_override=1 with park_req=1 and lane=001 -> all outputs 0; release -> IDLE, then park granted next edge.
//  - Park: park_req=1, park_dir=10 during COOLDOWN -> grant=10, steer_dir=10; park_dir=11 -> steer_en=0.
//    park_req=0 -> IDLE.
//  - Chime (macro on): 40 cycles in LANE_ACTIVE -> lane_warn 1 for 16, 0 for 16, 1 for 8, then 0 on exit.

Source files
------------

// File: rtl/steer_arb_pkg.sv
// Shared types and codes for the steering actuator arbiter and the lane assist FSM.
// Optional chime behaviour is enabled in the arbiter with macro LANE_WARN_CHIME_EN.
package steer_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DEBOUNCE,
        LANE_ACTIVE,
        COOLDOWN,
        PARK_ACTIVE,
        OVERRIDE
    } state_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_LANE = 2'b01;
    localparam logic [1:0] GRANT_PARK = 2'b10;

    // {left,right}
    localparam logic [1:0] DIR_NONE  = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;

    localparam logic [2:0] DISABLE      = 3'b000;
    localparam logic [2:0] ENABLE       = 3'b010;
    localparam logic [2:0] ASSIST_RIGHT = 3'b001;
    localparam logic [2:0] ASSIST_LEFT  = 3'b100;

    // Only the two assist codes request the actuator; every other code is treated as idle.
    function automatic logic is_lane_req(input logic [2:0] code);
        return (code == ASSIST_RIGHT) || (code == ASSIST_LEFT);
    endfunction

    function automatic logic [1:0] lane_to_dir(input logic [2:0] code);
        logic [1:0] dir;
        dir = DIR_NONE;
        if (code == ASSIST_RIGHT) dir = DIR_RIGHT;
        else if (code == ASSIST_LEFT) dir = DIR_LEFT;
        return dir;
    endfunction

    function automatic logic park_dir_valid(input logic [1:0] dir);
        return (dir == DIR_RIGHT) || (dir == DIR_LEFT);
    endfunction

endpackage

// File: rtl/lane_warn_chime.sv
// Audible lane warning cadence derived from the arbiter's correction counter.
// Present only when LANE_WARN_CHIME_EN is defined.
`ifdef LANE_WARN_CHIME_EN
module lane_warn_chime #(
    parameter int HALF_PERIOD = 16,
    parameter int CNT_W       = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             active,
    input  logic [CNT_W-1:0] cnt,
    output logic             lane_warn
);

    logic [CNT_W-1:0] phase;

    // cnt restarts at 0 on correction entry, so even phases are the "on" half-periods.
    always_comb begin
        phase = cnt / CNT_W'(HALF_PERIOD);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            lane_warn <= 1'b0;
        end else begin
            lane_warn <= active && !phase[0];
        end
    end

endmodule
`endif

// File: rtl/steering_arbiter.sv
// Shares the EPS actuator between lane assist and park assist; driver torque overrides all.
// Define LANE_WARN_CHIME_EN to add the lane_warn output and WARN_HALF_PERIOD parameter.
module steering_arbiter
    import steer_arb_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES    = 4,
    parameter int MAX_CORRECT_CYCLES = 200,
    parameter int COOLDOWN_CYCLES    = 50,
    parameter int CNT_W              = 8
`ifdef LANE_WARN_CHIME_EN
    ,
    parameter int WARN_HALF_PERIOD   = 16
`endif
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [2:0] lane,
    input  logic       driver_override,
    input  logic       park_req,
    input  logic [1:0] park_dir,
    output logic       steer_en,
    output logic [1:0] steer_dir,
    output logic [1:0] grant,
    output logic       timeout_flag
`ifdef LANE_WARN_CHIME_EN
    ,
    output logic       lane_warn
`endif
);

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CORR_LAST = CNT_W'(MAX_CORRECT_CYCLES - 1);
    localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'(COOLDOWN_CYCLES - 1);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       lat_code, lat_code_n;
    logic             steer_en_n;
    logic [1:0]       steer_dir_n;
    logic [1:0]       grant_n;
    logic             timeout_n;
    logic             lane_req;
    logic             lane_same;

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        lat_code_n = lat_code;
        timeout_n  = 1'b0;
        lane_req   = is_lane_req(lane);
        lane_same  = (lane == lat_code);

        if (driver_override) begin
            state_n    = OVERRIDE;
            cnt_n      = '0;
            lat_code_n = DISABLE;
        end else begin
            case (state)
                IDLE: begin
                    if (park_req) begin
                        state_n = PARK_ACTIVE;
                        cnt_n   = '0;
                    end else if (lane_req) begin
                        state_n    = DEBOUNCE;
                        lat_code_n = lane;
                        cnt_n      = CNT_W'(1);
                    end
                end
                DEBOUNCE: begin
                    if (park_req) begin
                        state_n = PARK_ACTIVE;
                        cnt_n   = '0;
                    end else if (!lane_same) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end else if (cnt == DEB_LAST) begin
                        state_n = LANE_ACTIVE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                LANE_ACTIVE: begin
                    // park_req is deliberately ignored until the correction finishes
                    if (!lane_same) begin
                        state_n = COOLDOWN;
                        cnt_n   = '0;
                    end else if (cnt == CORR_LAST) begin
                        state_n   = COOLDOWN;
                        cnt_n     = '0;
                        timeout_n = 1'b1;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                COOLDOWN: begin
                    if (park_req) begin
                        state_n = PARK_ACTIVE;
                        cnt_n   = '0;
                    end else if (cnt == COOL_LAST) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                PARK_ACTIVE: begin
                    if (!park_req) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end
                end
                OVERRIDE: begin
                    state_n    = IDLE;
                    cnt_n      = '0;
                    lat_code_n = DISABLE;
                end
                default: begin
                    state_n    = IDLE;
                    cnt_n      = '0;
                    lat_code_n = DISABLE;
                end
            endcase
        end
    end

    // Outputs are a function of the state being entered so they are registered with it.
    always_comb begin
        steer_en_n  = 1'b0;
        steer_dir_n = DIR_NONE;
        grant_n     = GRANT_NONE;
        case (state_n)
            LANE_ACTIVE: begin
                steer_en_n  = 1'b1;
                steer_dir_n = lane_to_dir(lat_code_n);
                grant_n     = GRANT_LANE;
            end
            PARK_ACTIVE: begin
                grant_n = GRANT_PARK;
                if (park_dir_valid(park_dir)) begin
                    steer_en_n  = 1'b1;
                    steer_dir_n = park_dir;
                end
            end
            default: begin
                steer_en_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= IDLE;
            cnt          <= '0;
            lat_code     <= DISABLE;
            steer_en     <= 1'b0;
            steer_dir    <= DIR_NONE;
            grant        <= GRANT_NONE;
            timeout_flag <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            lat_code     <= lat_code_n;
            steer_en     <= steer_en_n;
            steer_dir    <= steer_dir_n;
            grant        <= grant_n;
            timeout_flag <= timeout_n;
        end
    end

`ifdef LANE_WARN_CHIME_EN
    lane_warn_chime #(
        .HALF_PERIOD (WARN_HALF_PERIOD),
        .CNT_W       (CNT_W)
    ) u_chime (
        .CLK       (CLK),
        .RST       (RST),
        .active    (state_n == LANE_ACTIVE),
        .cnt       (cnt_n),
        .lane_warn (lane_warn)
    );
`endif

endmodule

// File: tb/tb_steering_arbiter.sv
// Randomised and directed scoreboard bench for steering_arbiter against a behavioural model.
// With LANE_WARN_CHIME_EN defined the lane_warn output is checked as well.
module tb_steering_arbiter;

    localparam int DEB  = 4;
    localparam int MAXC = 200;
    localparam int COOL = 50;
    localparam int HALF = 16;

    logic       CLK = 1'b0;
    logic       RST;
    logic [2:0] lane;
    logic       driver_override;
    logic       park_req;
    logic [1:0] park_dir;
    logic       steer_en;
    logic [1:0] steer_dir;
    logic [1:0] grant;
    logic       timeout_flag;
`ifdef LANE_WARN_CHIME_EN
    logic       lane_warn;
`endif

    always #5 CLK = ~CLK;

    steering_arbiter dut (
        .CLK             (CLK),
        .RST             (RST),
        .lane            (lane),
        .driver_override (driver_override),
        .park_req        (park_req),
        .park_dir        (park_dir),
        .steer_en        (steer_en),
        .steer_dir       (steer_dir),
        .grant           (grant),
        .timeout_flag    (timeout_flag)
`ifdef LANE_WARN_CHIME_EN
        ,
        .lane_warn       (lane_warn)
`endif
    );

    typedef struct packed {
        logic       en;
        logic [1:0] dir;
        logic [1:0] grant;
        logic       tf;
        logic       warn;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   n_push = 0;
    int   n_pop  = 0;

    // Behavioural model: who owns the actuator and how long each phase has run.
    bit         m_ovr;
    bit         m_park;
    bit         m_on;
    int         m_deb;
    int         m_on_cyc;
    int         m_cool;
    logic [2:0] m_code;

    task automatic model_step(input logic r, input logic [2:0] ln, input logic ov,
                              input logic pr, input logic [1:0] pd, output exp_t e);
        bit req;
        req = (ln == 3'b001) || (ln == 3'b100);
        e = '0;
        if (r) begin
            m_ovr = 0; m_park = 0; m_on = 0; m_deb = 0; m_cool = 0; m_code = 3'b000;
        end else if (ov) begin
            m_ovr = 1; m_park = 0; m_on = 0; m_deb = 0; m_cool = 0;
        end else if (m_ovr) begin
            m_ovr = 0;
        end else if (m_on) begin
            if (ln != m_code) begin
                m_on = 0; m_cool = COOL;
            end else if (m_on_cyc == MAXC) begin
                m_on = 0; m_cool = COOL; e.tf = 1'b1;
            end else begin
                m_on_cyc++;
            end
        end else if (m_park) begin
            if (!pr) m_park = 0;
        end else if (pr) begin
            m_park = 1; m_deb = 0; m_cool = 0;
        end else if (m_cool > 0) begin
            m_cool--;
        end else if (m_deb > 0) begin
            if (ln != m_code) begin
                m_deb = 0;
            end else begin
                m_deb++;
                if (m_deb == DEB) begin
                    m_deb = 0; m_on = 1; m_on_cyc = 1;
                end
            end
        end else if (req) begin
            m_deb = 1; m_code = ln;
        end

        if (m_on) begin
            e.en    = 1'b1;
            e.grant = 2'b01;
            e.dir   = (m_code == 3'b001) ? 2'b01 : 2'b10;
            e.warn  = (((m_on_cyc - 1) / HALF) % 2) == 0;
        end else if (m_park) begin
            e.grant = 2'b10;
            if (pd == 2'b01 || pd == 2'b10) begin
                e.en  = 1'b1;
                e.dir = pd;
            end
        end
    endtask

    task automatic step(input logic r, input logic [2:0] ln, input logic ov,
                        input logic pr, input logic [1:0] pd);
        exp_t e;
        RST             = r;
        lane            = ln;
        driver_override = ov;
        park_req        = pr;
        park_dir        = pd;
        model_step(r, ln, ov, pr, pd, e);
        sb_q.push_back(e);
        n_push++;
        @(posedge CLK);
        #1;
    endtask

    // Monitor: every cycle the DUT has outputs for a pushed expectation, compare them.
    always @(negedge CLK) begin
        exp_t e;
        bit   bad;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_pop++;
            bad = (steer_en !== e.en) || (steer_dir !== e.dir) ||
                  (grant !== e.grant) || (timeout_flag !== e.tf);
`ifdef LANE_WARN_CHIME_EN
            bad = bad || (lane_warn !== e.warn);
            if (bad)
                $display("FAIL outputs cycle %0d: got en=%b dir=%b grant=%b tf=%b warn=%b, want en=%b dir=%b grant=%b tf=%b warn=%b",
                         n_pop, steer_en, steer_dir, grant, timeout_flag, lane_warn,
                         e.en, e.dir, e.grant, e.tf, e.warn);
`else
            if (bad)
                $display("FAIL outputs cycle %0d: got en=%b dir=%b grant=%b tf=%b, want en=%b dir=%b grant=%b tf=%b",
                         n_pop, steer_en, steer_dir, grant, timeout_flag,
                         e.en, e.dir, e.grant, e.tf);
`endif
            n_cmp++;
            if (bad) n_bad++;
        end
    end

    logic [2:0] lane_tab [0:7] = '{3'b001, 3'b100, 3'b001, 3'b100,
                                   3'b010, 3'b000, 3'b011, 3'b110};

    initial begin
        // reset
        step(1, 3'b010, 0, 0, 2'b00);
        step(1, 3'b001, 1, 1, 2'b01);

        // debounce to correction, then release into cooldown
        repeat (8) step(0, 3'b001, 0, 0, 2'b00);
        repeat (55) step(0, 3'b010, 0, 0, 2'b00);

        // short request never reaches the actuator
        repeat (2) step(0, 3'b100, 0, 0, 2'b00);
        repeat (10) step(0, 3'b010, 0, 0, 2'b00);

        // long hold: timeout, cooldown, re-debounce
        repeat (300) step(0, 3'b100, 0, 0, 2'b00);
        repeat (60) step(0, 3'b010, 0, 0, 2'b00);

        // override beats park and lane, release hands actuator to park
        repeat (5) step(0, 3'b001, 1, 1, 2'b10);
        repeat (4) step(0, 3'b001, 0, 1, 2'b10);
        repeat (3) step(0, 3'b010, 0, 0, 2'b00);

        // park during cooldown, invalid park direction, release
        repeat (10) step(0, 3'b001, 0, 0, 2'b00);
        step(0, 3'b010, 0, 0, 2'b00);
        repeat (4) step(0, 3'b010, 0, 1, 2'b10);
        repeat (3) step(0, 3'b010, 0, 1, 2'b11);
        repeat (2) step(0, 3'b010, 0, 1, 2'b01);
        repeat (3) step(0, 3'b010, 0, 0, 2'b01);

        // park requested mid-correction is ignored
        repeat (8) step(0, 3'b100, 0, 0, 2'b00);
        repeat (4) step(0, 3'b100, 0, 1, 2'b01);
        repeat (3) step(0, 3'b010, 0, 1, 2'b01);
        repeat (2) step(0, 3'b010, 0, 0, 2'b00);

        // reset while correcting, then re-debounce
        repeat (8) step(0, 3'b001, 0, 0, 2'b00);
        step(1, 3'b001, 0, 0, 2'b00);
        repeat (8) step(0, 3'b001, 0, 0, 2'b00);
        step(0, 3'b010, 0, 0, 2'b00);
        repeat (52) step(0, 3'b000, 0, 0, 2'b00);

        // chime cadence over a 40-cycle correction
        repeat (43) step(0, 3'b100, 0, 0, 2'b00);
        repeat (3) step(0, 3'b010, 0, 0, 2'b00);

        // randomised held segments
        for (int s = 0; s < 70; s++) begin
            logic [2:0] ln;
            logic       ov_seg;
            logic       pr_seg;
            int         len;
            ln     = lane_tab[$urandom_range(0, 7)];
            if ($urandom_range(0, 3) == 0) ln = 3'($urandom_range(0, 7));
            ov_seg = ($urandom_range(0, 11) == 0);
            pr_seg = ($urandom_range(0, 3) == 0);
            len    = ($urandom_range(0, 2) == 0) ? $urandom_range(150, 260)
                                                 : $urandom_range(1, 12);
            for (int c = 0; c < len; c++) begin
                logic r;
                logic ov;
                r  = (c == 0) && ($urandom_range(0, 39) == 0);
                ov = ov_seg || ($urandom_range(0, 199) == 0);
                step(r, ln, ov, pr_seg, 2'($urandom_range(0, 3)));
            end
        end

        repeat (2) @(negedge CLK);
        #1;
        n_cmp++;
        if (sb_q.size() != 0 || n_pop != n_push) begin
            n_bad++;
            $display("FAIL drain: got %0d checked of %0d issued, want all checked", n_pop, n_push);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
